// File: rtl/float_div_pkg.sv
// Shared definitions for the floating-point divide scheduler.
//   - state_e       : scheduler FSM encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   - FP_*          : IEEE-754 single-precision field positions and the all-ones exponent
//   - fp_signed_inf : builds a signed infinity
//   - fp_mag_zero   : true for +0 / -0
package float_div_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  localparam logic [7:0]  FP_EXP_INF  = 8'hFF;
  localparam int unsigned FP_SIGN_BIT = 31;
  localparam int unsigned FP_EXP_MSB  = 30;
  localparam int unsigned FP_EXP_LSB  = 23;
  localparam int unsigned FP_MAN_MSB  = 22;
  localparam int unsigned FP_MAN_LSB  = 0;

  function automatic logic [31:0] fp_signed_inf(input logic sign);
    logic [31:0] r;
    r                          = '0;
    r[FP_SIGN_BIT]             = sign;
    r[FP_EXP_MSB:FP_EXP_LSB]   = FP_EXP_INF;
    r[FP_MAN_MSB:FP_MAN_LSB]   = '0;
    return r;
  endfunction

  // Sign bit is ignored: both +0 and -0 count as zero.
  function automatic logic fp_mag_zero(input logic [31:0] x);
    return x[FP_EXP_MSB:FP_MAN_LSB] == '0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req         : request vector
//   last_grant  : index granted most recently; search starts one above it and wraps
//   grant       : one-hot winner (all zero when no request)
//   grant_idx   : binary index of the winner
//   grant_valid : at least one request present
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  localparam int unsigned SW = IDX_W + 1;

  logic [SW-1:0]  shift;
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   pick_rot;
  logic [SW-1:0]  pick_j;
  logic [2*N-1:0] gnt_dbl;
  logic [SW-1:0]  sum;

  // Rotate so that bit 0 of rot is requester last_grant+1, pick the lowest set bit,
  // then rotate the one-hot pick back into requester order.
  always_comb begin
    shift       = SW'(last_grant) + SW'(1);
    req_dbl     = {req, req};
    rot         = N'(req_dbl >> shift);
    pick_rot    = '0;
    pick_j      = '0;
    grant_valid = 1'b0;
    for (int j = 0; j < int'(N); j++) begin
      if (!grant_valid && rot[j]) begin
        grant_valid = 1'b1;
        pick_rot[j] = 1'b1;
        pick_j      = SW'(j);
      end
    end
    gnt_dbl = {{N{1'b0}}, pick_rot} << shift;
    grant   = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];
    sum     = shift + pick_j;
    if (sum >= SW'(N)) begin
      sum = sum - SW'(N);
    end
    grant_idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/float_div_scheduler.sv
// Shares one single-precision divide unit among NUM_REQ requesters, one request at a time.
//   clk, reset            : clock, asynchronous active-high reset
//   req_valid/req_ready   : per-requester handshake; req_ready is a one-hot grant in IDLE
//   req_a, req_b          : packed dividends/divisors, requester i at [32i+31:32i]
//   resp_valid/resp_ready : result handshake
//   resp_id/data/dbz      : owner, quotient, divide-by-zero flag
//   div_a, div_b          : operands to the external divider
//   div_enable            : one-cycle start pulse to the divider
//   div_out               : divider quotient, valid DIV_LATENCY cycles after div_enable
module float_div_scheduler
  import float_div_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DIV_LATENCY = 2,
  parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_data,
  output logic                  resp_dbz,
  output logic [31:0]           div_a,
  output logic [31:0]           div_b,
  output logic                  div_enable,
  input  logic [31:0]           div_out
);

  localparam int unsigned CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ID_W-1:0]    last_grant_q;
  logic [ID_W-1:0]    id_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [31:0]        resp_data_q;
  logic               resp_valid_q;
  logic               resp_dbz_q;
  logic               div_enable_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic               accept;
  logic               sel_dbz;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req         (req_valid),
    .last_grant  (last_grant_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_any)
  );

  // One-hot operand mux driven by the arbiter's grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  assign accept  = (state_q == StIdle) && grant_any;
  assign sel_dbz = fp_mag_zero(sel_b);

  // Grant depends only on registered state and req_valid, never on resp_ready.
  assign req_ready = ((state_q == StIdle) && !reset) ? grant : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_dbz_q   <= 1'b0;
      div_enable_q <= 1'b0;
    end else begin
      div_enable_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            id_q         <= grant_idx;
            last_grant_q <= grant_idx;
            if (sel_dbz) begin
              // Resolved locally; divider operands keep their last issued values.
              resp_data_q  <= fp_signed_inf(sel_a[FP_SIGN_BIT] ^ sel_b[FP_SIGN_BIT]);
              resp_dbz_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= StResp;
            end else begin
              a_q          <= sel_a;
              b_q          <= sel_b;
              div_enable_q <= 1'b1;
              state_q      <= StIssue;
            end
          end
        end
        StIssue: begin
          cnt_q   <= CNT_W'(DIV_LATENCY - 1);
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == '0) begin
            resp_data_q  <= div_out;
            resp_dbz_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = id_q;
  assign resp_data  = resp_data_q;
  assign resp_dbz   = resp_dbz_q;
  assign div_a      = a_q;
  assign div_b      = b_q;
  assign div_enable = div_enable_q;

endmodule

// File: tb/tb_float_div_scheduler.sv
// Directed bench for float_div_scheduler (NUM_REQ=4, DIV_LATENCY=2) with a two-stage
// divider stand-in. Inputs are driven and outputs sampled around the falling edge.
module tb_float_div_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [31:0]  resp_data;
  logic         resp_dbz;
  logic [31:0]  div_a;
  logic [31:0]  div_b;
  logic         div_enable;
  logic [31:0]  div_out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  float_div_scheduler #(
    .NUM_REQ     (4),
    .DIV_LATENCY (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_dbz   (resp_dbz),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_enable (div_enable),
    .div_out    (div_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Known vector 6.0/2.0 = 3.0; anything else maps to an arbitrary operand hash so
  // routing mistakes show up as wrong data.
  function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // Quotient appears exactly two cycles after the enable cycle; garbage otherwise.
  logic [31:0] p1, p2;
  always @(posedge clk) begin
    p1 <= div_enable ? div_model(div_a, div_b) : 32'hDEAD_BEEF;
    p2 <= p1;
  end
  assign div_out = p2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // Called just after a falling edge; returns the granted index and its cycle number.
  task automatic wait_grant(output int idx, output int t);
    int timed_out;
    idx       = -1;
    t         = -1;
    timed_out = 1;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (|(req_valid & req_ready)) begin
        for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) idx = i;
        t         = cyc;
        timed_out = 0;
        break;
      end
      @(negedge clk);
    end
    check("grant_timeout", 32'(timed_out), 32'd0);
  endtask

  logic [31:0] fa [4];
  logic [31:0] fb [4];
  int idx, t, prev, t0;

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state, including grant suppression while reset is high
    req_valid = 4'hF;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_dbz", 32'(resp_dbz), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_div_a", div_a, 32'd0);
    check("rst_div_b", div_b, 32'd0);
    check("rst_div_enable", 32'(div_enable), 32'd0);

    // Fairness: all four valid, grant order 0,1,2,3,0,1 five cycles apart
    for (int i = 0; i < 4; i++) begin
      fa[i] = 32'h4100_0000 + (i << 20);
      fb[i] = 32'h3F80_0001 + i;
      set_req(i, fa[i], fb[i]);
    end
    @(negedge clk);
    reset = 1'b0;
    prev  = 0;
    for (int g = 0; g < 6; g++) begin
      wait_grant(idx, t);
      check("fair_id", 32'(idx), 32'(g % 4));
      if (g > 0) check("fair_gap", 32'(t - prev), 32'd5);
      prev = t;
      repeat (4) @(negedge clk);
      check("fair_resp_valid", 32'(resp_valid), 32'd1);
      check("fair_resp_id", 32'(resp_id), 32'(g % 4));
      check("fair_resp_data", resp_data, div_model(fa[g % 4], fb[g % 4]));
      if (g == 5) req_valid = '0;
    end

    // Single request: 6.0 / 2.0 from requester 0
    @(negedge clk);
    set_req(0, 32'h40C0_0000, 32'h4000_0000);
    req_valid = 4'b0001;
    wait_grant(idx, t);
    check("single_id", 32'(idx), 32'd0);
    check("single_en_T", 32'(div_enable), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = '0;
      check("single_div_enable", 32'(div_enable), 32'(k == 1));
      check("single_resp_valid", 32'(resp_valid), 32'(k == 4));
      if (k == 2) begin
        check("single_div_a", div_a, 32'h40C0_0000);
        check("single_div_b", div_b, 32'h4000_0000);
      end
    end
    check("single_data", resp_data, 32'h4040_0000);
    check("single_resp_id", 32'(resp_id), 32'd0);
    check("single_dbz", 32'(resp_dbz), 32'd0);

    // Divide by zero: -1/+0 then +1/-0, two cycles apart, divider untouched
    @(negedge clk);
    set_req(1, 32'hBF80_0000, 32'h0000_0000);
    req_valid = 4'b0010;
    wait_grant(idx, t);
    check("dbz1_id", 32'(idx), 32'd1);
    @(negedge clk);
    req_valid = '0;
    check("dbz1_resp_valid", 32'(resp_valid), 32'd1);
    check("dbz1_data", resp_data, 32'hFF80_0000);
    check("dbz1_flag", 32'(resp_dbz), 32'd1);
    check("dbz1_resp_id", 32'(resp_id), 32'd1);
    check("dbz1_div_enable", 32'(div_enable), 32'd0);
    check("dbz1_div_a_held", div_a, 32'h40C0_0000);
    set_req(3, 32'h3F80_0000, 32'h8000_0000);
    req_valid = 4'b1000;
    prev      = t;
    wait_grant(idx, t);
    check("dbz2_id", 32'(idx), 32'd3);
    check("dbz2_gap", 32'(t - prev), 32'd2);
    @(negedge clk);
    req_valid = '0;
    check("dbz2_data", resp_data, 32'hFF80_0000);
    check("dbz2_flag", 32'(resp_dbz), 32'd1);
    check("dbz2_resp_id", 32'(resp_id), 32'd3);
    check("dbz2_div_enable", 32'(div_enable), 32'd0);

    // Backpressure: five cycles of resp_ready low in RESP, next grant at R+1
    @(negedge clk);
    resp_ready = 1'b0;
    set_req(2, 32'h4120_0000, 32'h40A0_0000);
    req_valid = 4'b0100;
    wait_grant(idx, t0);
    check("bp_id", 32'(idx), 32'd2);
    @(negedge clk);
    set_req(0, 32'h4200_0000, 32'h4080_0000);
    req_valid = 4'b0001;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_data", resp_data, div_model(32'h4120_0000, 32'h40A0_0000));
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    check("bp_no_grant_R", 32'(req_ready), 32'd0);
    wait_grant(idx, t);
    check("bp_next_id", 32'(idx), 32'd0);
    check("bp_next_gap", 32'(t - t0), 32'd10);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("bp2_resp_valid", 32'(resp_valid), 32'd1);
    check("bp2_resp_id", 32'(resp_id), 32'd0);
    check("bp2_resp_data", resp_data, div_model(32'h4200_0000, 32'h4080_0000));

    // Reset during WAIT with requester 2 in flight
    @(negedge clk);
    set_req(2, 32'h4160_0000, 32'h4040_0000);
    req_valid = 4'b0100;
    wait_grant(idx, t);
    check("rw_id", 32'(idx), 32'd2);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("rw_div_a_pre", div_a, 32'h4160_0000);
    reset     = 1'b1;
    req_valid = 4'b0101;
    #1;
    check("rw_resp_valid", 32'(resp_valid), 32'd0);
    check("rw_div_enable", 32'(div_enable), 32'd0);
    check("rw_div_a_async", div_a, 32'd0);
    check("rw_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_grant(idx, t);
    check("rw_first_id", 32'(idx), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = '0;
      check("rw_resp_valid_seq", 32'(resp_valid), 32'(k == 4));
    end
    check("rw_resp_id", 32'(resp_id), 32'd0);
    check("rw_resp_data", resp_data, div_model(32'h4200_0000, 32'h4080_0000));

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
